// File: rtl/div_seq_pkg.sv
// ============================================================================
// Module      : div_seq_pkg
// Description : Shared types and constants for the divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_ITER_A = 3'd2,
        S_ITER_B = 3'd3,
        S_QUOT   = 3'd4,
        S_REM    = 3'd5,
        S_SELECT = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        OP_BX = 2'd0,
        OP_XT = 2'd1,
        OP_AX = 2'd2,
        OP_EB = 2'd3
    } mul_op_t;

    // Newton iteration counts for double and single precision
    localparam logic [1:0] ITER_DBL = 2'd3;
    localparam logic [1:0] ITER_SGL = 2'd2;

endpackage

`default_nettype wire

// File: rtl/div_iter_cnt.sv
// ============================================================================
// Module      : div_iter_cnt
// Description : Newton iteration counter with precision-dependent terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_iter_cnt
    import div_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic       dbl,
    output logic [1:0] iter,
    output logic       last
);

    logic [1:0] r_iter;
    logic [1:0] w_term;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iter <= 2'd0;
        end else if (clr) begin
            r_iter <= 2'd0;
        end else if (inc) begin
            r_iter <= r_iter + 2'd1;
        end
    end

    // last compares the pre-increment value, so the final pass is iteration N-1
    assign w_term = dbl ? (ITER_DBL - 2'd1) : (ITER_SGL - 2'd1);
    assign last   = (r_iter == w_term);
    assign iter   = r_iter;

endmodule

`default_nettype wire

// File: rtl/div_sequencer.sv
// ============================================================================
// Module      : div_sequencer
// Description : Control sequencer for a Newton-Raphson divider sharing one multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_sequencer
    import div_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       db,
    output logic       busy,
    output logic       done,
    output logic       mul_req,
    input  logic       mul_ack,
    output logic [1:0] mul_op,
    output logic       ld_x,
    output logic       ld_t,
    output logic       ld_e,
    output logic       ld_eb,
    output logic       sel_en,
    output logic       db_q,
    output logic [1:0] iter
);

    state_t  r_state;
    state_t  w_next_state;
    mul_op_t w_op;
    logic    r_db_q;
    logic    w_cnt_clr;
    logic    w_cnt_inc;
    logic    w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_q <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_db_q <= db;
        end
    end

    div_iter_cnt u_iter_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_cnt_clr),
        .inc  (w_cnt_inc),
        .dbl  (r_db_q),
        .iter (iter),
        .last (w_last)
    );

    // Load strobes are gated by state, so an ack seen outside a multiply state is inert
    always_comb begin
        w_next_state = r_state;
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        mul_req      = 1'b0;
        w_op         = OP_BX;
        ld_x         = 1'b0;
        ld_t         = 1'b0;
        ld_e         = 1'b0;
        ld_eb        = 1'b0;
        sel_en       = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_cnt_clr    = 1'b1;
                    w_next_state = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                ld_x         = 1'b1;
                w_next_state = S_ITER_A;
            end
            S_ITER_A: begin
                mul_req = 1'b1;
                w_op    = OP_BX;
                if (mul_ack) begin
                    ld_t         = 1'b1;
                    w_next_state = S_ITER_B;
                end
            end
            S_ITER_B: begin
                mul_req = 1'b1;
                w_op    = OP_XT;
                if (mul_ack) begin
                    ld_x         = 1'b1;
                    w_cnt_inc    = 1'b1;
                    w_next_state = w_last ? S_QUOT : S_ITER_A;
                end
            end
            S_QUOT: begin
                mul_req = 1'b1;
                w_op    = OP_AX;
                if (mul_ack) begin
                    ld_e         = 1'b1;
                    w_next_state = S_REM;
                end
            end
            S_REM: begin
                mul_req = 1'b1;
                w_op    = OP_EB;
                if (mul_ack) begin
                    ld_eb        = 1'b1;
                    w_next_state = S_SELECT;
                end
            end
            S_SELECT: begin
                sel_en       = 1'b1;
                w_next_state = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign mul_op = w_op;
    assign db_q   = r_db_q;

endmodule

`default_nettype wire

// File: tb/tb_div_sequencer.sv
// ============================================================================
// Module      : tb_div_sequencer
// Description : Directed self-checking bench for div_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       db;
    logic       busy;
    logic       done;
    logic       mul_req;
    logic       mul_ack;
    logic [1:0] mul_op;
    logic       ld_x;
    logic       ld_t;
    logic       ld_e;
    logic       ld_eb;
    logic       sel_en;
    logic       db_q;
    logic [1:0] iter;

    int tests;
    int fails;

    // multiplier model controls
    int   ack_delay;
    int   ack_age;
    logic force_ack;

    // per-operation statistics
    int          busy_n;
    int          done_n;
    int          done_at;
    int          ldx_n;
    int          multi_n;
    int          dbq_bad;
    int          opidle_bad;
    int          hold_bad;
    logic [31:0] seq;
    logic [1:0]  iter_first;
    logic [1:0]  iter_last;

    div_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .db      (db),
        .busy    (busy),
        .done    (done),
        .mul_req (mul_req),
        .mul_ack (mul_ack),
        .mul_op  (mul_op),
        .ld_x    (ld_x),
        .ld_t    (ld_t),
        .ld_e    (ld_e),
        .ld_eb   (ld_eb),
        .sel_en  (sel_en),
        .db_q    (db_q),
        .iter    (iter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier answers after ack_delay waiting cycles of a held request
    always @(negedge clk) begin
        if (mul_req) begin
            mul_ack = force_ack || (ack_age == ack_delay);
            ack_age = (ack_age == ack_delay) ? 0 : ack_age + 1;
        end else begin
            mul_ack = force_ack;
            ack_age = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start one operation and sample every busy cycle; pulse start again at busy cycles p1/p2
    task automatic run_op(input logic dbv, input int p1, input int p2);
        logic       prev_wait;
        logic [1:0] prev_op;
        int         nsel;
        busy_n = 0; done_n = 0; done_at = 0; ldx_n = 0; multi_n = 0;
        dbq_bad = 0; opidle_bad = 0; hold_bad = 0; seq = 32'd0;
        iter_first = 2'd3; iter_last = 2'd0;
        prev_wait = 1'b0; prev_op = 2'd0;
        @(negedge clk);
        start = 1'b1;
        db    = dbv;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start = 1'b0;
            db    = ~dbv;
            #1;
            if (!busy) break;
            busy_n++;
            if (busy_n == 1) iter_first = iter;
            iter_last = iter;
            if (done) begin done_n++; done_at = busy_n; end
            if (ld_x) ldx_n++;
            nsel = int'(ld_x) + int'(ld_t) + int'(ld_e) + int'(ld_eb) + int'(sel_en);
            if (nsel > 1) multi_n++;
            if (db_q !== dbv) dbq_bad++;
            if (!mul_req && mul_op !== 2'd0) opidle_bad++;
            if (prev_wait && (!mul_req || mul_op !== prev_op)) hold_bad++;
            if (mul_req && mul_ack) seq = {seq[29:0], mul_op};
            prev_wait = mul_req && !mul_ack;
            prev_op   = mul_op;
            if (busy_n == p1 || busy_n == p2) start = 1'b1;
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        ack_delay = 0; ack_age = 0; force_ack = 1'b0; mul_ack = 1'b0;
        start = 1'b0; db = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs",
              {30'd0, busy, done, mul_req, ld_x, ld_t, ld_e, ld_eb, sel_en, db_q, iter, mul_op},
              32'd0);
        @(negedge clk);
        rst = 1'b0;

        // double precision, zero-wait ack
        run_op(1'b1, 0, 0);
        check("dbl_busy_cycles", busy_n, 11);
        check("dbl_op_seq", seq, 32'h0000_111B);
        check("dbl_done_at", done_at, 11);
        check("dbl_done_count", done_n, 1);
        check("dbl_ldx_pulses", ldx_n, 4);
        check("dbl_onehot_loads", multi_n, 0);
        check("dbl_dbq_stable", dbq_bad, 0);
        check("dbl_iter_first", iter_first, 0);
        check("dbl_iter_last", iter_last, 3);

        // single precision, zero-wait ack
        run_op(1'b0, 0, 0);
        check("sgl_busy_cycles", busy_n, 9);
        check("sgl_op_seq", seq, 32'h0000_011B);
        check("sgl_dbq_stable", dbq_bad, 0);
        check("sgl_ldx_pulses", ldx_n, 3);
        check("sgl_iter_last", iter_last, 2);
        check("sgl_op_idle_bx", opidle_bad, 0);

        // double precision, three waiting cycles per request
        ack_delay = 3;
        run_op(1'b1, 0, 0);
        check("slow_busy_cycles", busy_n, 35);
        check("slow_op_seq", seq, 32'h0000_111B);
        check("slow_hold", hold_bad, 0);
        check("slow_op_idle_bx", opidle_bad, 0);
        check("slow_done_at", done_at, 35);
        ack_delay = 0;

        // start re-pulsed during ITER_B (cycle 3) and DONE (cycle 11)
        run_op(1'b1, 3, 11);
        check("restart_busy_cycles", busy_n, 11);
        check("restart_done_count", done_n, 1);
        done_n = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (busy || done) done_n++;
        end
        check("restart_stays_idle", done_n, 0);

        // reset asserted while in QUOT (busy cycle 8, double, zero-wait)
        @(negedge clk);
        start = 1'b1; db = 1'b1;
        busy_n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (busy) busy_n++;
        end
        check("abort_reached_quot", {30'd0, mul_req, mul_op}, {29'd0, 1'b1, 2'd2});
        rst = 1'b1;
        #1;
        check("abort_outputs_zero",
              {30'd0, busy, done, mul_req, ld_x, ld_t, ld_e, ld_eb, sel_en, db_q, iter, mul_op},
              32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (busy || done) done_n++;
        end
        check("abort_no_done", done_n, 0);
        run_op(1'b1, 0, 0);
        check("after_abort_busy", busy_n, 11);
        check("after_abort_done", done_n, 1);

        // ack forced high while idle
        force_ack = 1'b1;
        done_n = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (busy || done || ld_x || ld_t || ld_e || ld_eb || sel_en || mul_req) done_n++;
        end
        force_ack = 1'b0;
        check("idle_ack_ignored", done_n, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
